// File: rtl/hcms_pkg.sv
// Shared types and constants for the HCMS-29xx serial transmitter.
package hcms_pkg;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    ST_RST_PULSE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_NEXT      = 3'd3,
    ST_HOLD      = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

  // Display RS encodings.
  localparam logic RS_DOT  = 1'b0;
  localparam logic RS_CTRL = 1'b1;

  // Control word 0: select=0, sleep_n=bit 6, peak current [5:4], brightness [3:0].
  typedef struct packed {
    logic       sel;
    logic       sleep_n;
    logic [1:0] peak;
    logic [3:0] bright;
  } cw0_t;

  // Control word 1: select=1, prescaler bit 1, serial/simultaneous bit 0.
  typedef struct packed {
    logic       sel;
    logic [4:0] rsvd;
    logic       prescale;
    logic       serial;
  } cw1_t;

endpackage

// File: rtl/hcms_serial_tx_if.sv
// Word stream handshake between the display controller and the transmitter.
interface hcms_serial_tx_if #(
  parameter int unsigned WORD_W = 8
) ();
  logic [WORD_W-1:0] data;
  logic              cmd;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (output data, output cmd, output last, output valid, input ready);
  modport slave  (input data, input cmd, input last, input valid, output ready);
endinterface

// File: rtl/hcms_clk_en.sv
// Restartable half-period counter; phase_done pulses every CLK_DIV cycles.
module hcms_clk_en #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic phase_done
);
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: wrap at the end of a half period, zero on restart.
  always_comb begin
    cnt_nxt = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == CNT_MAX)) begin
      cnt_nxt = '0;
    end
  end

  // Count register; phase_done is registered so it is high while the count sits at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      phase_done <= (CLK_DIV == 1);
    end else begin
      cnt_q      <= cnt_nxt;
      phase_done <= (cnt_nxt == CNT_MAX);
    end
  end
endmodule

// File: rtl/hcms_serial_tx.sv
// Serial transmitter for HCMS-29xx displays: framing, bit shifting and reset pulse.
module hcms_serial_tx
  import hcms_pkg::*;
#(
  parameter int unsigned WORD_W       = 8,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic                   CLK_i,
  input  logic                   RST_ni,
  hcms_serial_tx_if.slave        s,
  input  logic                   DISP_RST,
  output logic                   BUSY,
  output logic                   SER_DATA,
  output logic                   SER_CLK,
  output logic                   REG_SEL,
  output logic                   nCE,
  output logic                   nRESET
);
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  state_e            state_q,   state_nxt;
  logic [WORD_W-1:0] sh_q,      sh_nxt;
  logic [BIT_W-1:0]  bit_q,     bit_nxt;
  logic [RST_W-1:0]  rcnt_q,    rcnt_nxt;
  logic              last_q,    last_nxt;
  logic              reg_sel_nxt;
  logic              ser_clk_nxt;
  logic              ready_q,   ready_nxt;
  logic              n_ce_nxt;
  logic              n_reset_nxt;
  logic              busy_nxt;
  logic              hs_c;
  logic              restart_c;
  logic              phase_done;

  hcms_clk_en #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_en (
    .clk       (CLK_i),
    .rst_n     (RST_ni),
    .restart   (restart_c),
    .phase_done(phase_done)
  );

  assign s.ready  = ready_q;
  assign SER_DATA = sh_q[WORD_W-1];

  // Next state, datapath and next output values.
  always_comb begin
    state_nxt   = state_q;
    sh_nxt      = sh_q;
    bit_nxt     = bit_q;
    rcnt_nxt    = rcnt_q;
    last_nxt    = last_q;
    reg_sel_nxt = REG_SEL;
    ser_clk_nxt = 1'b0;
    hs_c        = s.valid & ready_q;

    unique case (state_q)
      ST_RST_PULSE: begin
        if (rcnt_q == RST_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          rcnt_nxt = rcnt_q + RST_W'(1);
        end
      end
      ST_IDLE: begin
        // Reset request wins; any offered word stays pending until the pulse ends.
        if (DISP_RST) begin
          state_nxt = ST_RST_PULSE;
          rcnt_nxt  = '0;
        end else if (hs_c) begin
          sh_nxt      = s.data;
          last_nxt    = s.last;
          reg_sel_nxt = s.cmd;
          bit_nxt     = '0;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_clk_nxt = SER_CLK;
        if (phase_done) begin
          if (!SER_CLK) begin
            ser_clk_nxt = 1'b1;
          end else begin
            ser_clk_nxt = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_nxt = last_q ? ST_HOLD : ST_NEXT;
            end else begin
              sh_nxt  = {sh_q[WORD_W-2:0], 1'b0};
              bit_nxt = bit_q + BIT_W'(1);
            end
          end
        end
      end
      ST_NEXT: begin
        // RS stays frozen for the whole frame; cmd is not sampled here.
        if (hs_c) begin
          sh_nxt    = s.data;
          last_nxt  = s.last;
          bit_nxt   = '0;
          state_nxt = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (phase_done) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (phase_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    restart_c   = (state_nxt != state_q);
    ready_nxt   = (state_nxt == ST_IDLE) || (state_nxt == ST_NEXT);
    n_ce_nxt    = !(state_nxt inside {ST_SHIFT, ST_NEXT, ST_HOLD});
    n_reset_nxt = (state_nxt != ST_RST_PULSE);
    busy_nxt    = (state_nxt != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state_q <= ST_RST_PULSE;
      sh_q    <= '0;
      bit_q   <= '0;
      rcnt_q  <= '0;
      last_q  <= 1'b0;
      REG_SEL <= RS_DOT;
      SER_CLK <= 1'b0;
      ready_q <= 1'b0;
      nCE     <= 1'b1;
      nRESET  <= 1'b0;
      BUSY    <= 1'b1;
    end else begin
      state_q <= state_nxt;
      sh_q    <= sh_nxt;
      bit_q   <= bit_nxt;
      rcnt_q  <= rcnt_nxt;
      last_q  <= last_nxt;
      REG_SEL <= reg_sel_nxt;
      SER_CLK <= ser_clk_nxt;
      ready_q <= ready_nxt;
      nCE     <= n_ce_nxt;
      nRESET  <= n_reset_nxt;
      BUSY    <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_hcms_serial_tx.sv
// Directed bench for hcms_serial_tx with WORD_W=8, CLK_DIV=2, RESET_CYCLES=16.
module tb_hcms_serial_tx;
  import hcms_pkg::*;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned H      = 2;
  localparam int unsigned RSTC   = 16;

  logic CLK_i = 1'b0;
  logic RST_ni;
  logic DISP_RST;
  logic BUSY, SER_DATA, SER_CLK, REG_SEL, nCE, nRESET;

  hcms_serial_tx_if #(.WORD_W(WORD_W)) s_if ();

  hcms_serial_tx #(
    .WORD_W      (WORD_W),
    .CLK_DIV     (H),
    .RESET_CYCLES(RSTC)
  ) dut (
    .CLK_i   (CLK_i),
    .RST_ni  (RST_ni),
    .s       (s_if),
    .DISP_RST(DISP_RST),
    .BUSY    (BUSY),
    .SER_DATA(SER_DATA),
    .SER_CLK (SER_CLK),
    .REG_SEL (REG_SEL),
    .nCE     (nCE),
    .nRESET  (nRESET)
  );

  always #5 CLK_i = ~CLK_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          rises    = 0;
  logic [63:0] rx       = '0;

  // Cycle counter and display-side capture of every SER_CLK rise.
  always @(posedge CLK_i) cyc <= cyc + 1;
  always @(posedge SER_CLK) begin
    rises <= rises + 1;
    rx    <= {rx[62:0], SER_DATA};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Offer a word starting at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic cmd, input logic last, output int t_acc);
    s_if.data  = d;
    s_if.cmd   = cmd;
    s_if.last  = last;
    s_if.valid = 1'b1;
    for (int i = 0; i < 400 && !s_if.ready; i++) @(negedge CLK_i);
    @(negedge CLK_i);
    s_if.valid = 1'b0;
    t_acc = cyc;
  endtask

  // Sample once per cycle until S_READY is high, tallying pin activity.
  task automatic run_to_ready(input logic exp_rs, output int n_lo, output int n_hi,
                              output int n_rs_bad, output int n_rst_lo, output logic [4:0] sc);
    n_lo = 0; n_hi = 0; n_rs_bad = 0; n_rst_lo = 0; sc = '0;
    for (int i = 0; i < 400 && !s_if.ready; i++) begin
      if (nCE) n_hi++; else n_lo++;
      if (REG_SEL !== exp_rs) n_rs_bad++;
      if (!nRESET) n_rst_lo++;
      if (i < 5) sc[i] = SER_CLK;
      @(negedge CLK_i);
    end
    if (!s_if.ready) chk("ready_timeout", 32'(s_if.ready), 1);
  endtask

  // Count cycles of a low nRESET pulse, starting at the current sample.
  task automatic pulse_len(output int n, output int n_ce_hi, output int n_rdy);
    n = 0; n_ce_hi = 0; n_rdy = 0;
    for (int i = 0; i < 400 && !nRESET; i++) begin
      n++;
      if (nCE) n_ce_hi++;
      if (s_if.ready) n_rdy++;
      @(negedge CLK_i);
    end
  endtask

  initial begin
    int t, n_lo, n_hi, n_rs, n_rl, n, n_ce_hi, n_rdy, r0, gap_ce, gap_clk;
    logic [4:0] sc;
    cw0_t cw0;
    cw1_t cw1;
    logic [7:0] w;

    RST_ni = 1'b0; DISP_RST = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0; s_if.cmd = 1'b0; s_if.last = 1'b0;
    repeat (3) @(negedge CLK_i);

    // Reset values
    chk("rst_nRESET", 32'(nRESET), 0);
    chk("rst_nCE", 32'(nCE), 1);
    chk("rst_SER_CLK", 32'(SER_CLK), 0);
    chk("rst_SER_DATA", 32'(SER_DATA), 0);
    chk("rst_REG_SEL", 32'(REG_SEL), 0);
    chk("rst_READY", 32'(s_if.ready), 0);
    chk("rst_BUSY", 32'(BUSY), 1);

    // Power-on pulse after release
    RST_ni = 1'b1;
    pulse_len(n, n_ce_hi, n_rdy);
    chk("por_len", 32'(n), 16);
    chk("por_nce_high", 32'(n_ce_hi), 16);
    chk("por_ready_low", 32'(n_rdy), 0);
    chk("por_ready_after", 32'(s_if.ready), 1);
    chk("por_busy_after", 32'(BUSY), 0);

    // Single control word 0xA5
    r0 = rises;
    send(8'hA5, 1'b1, 1'b1, t);
    chk("sw_nce_first", 32'(nCE), 0);
    chk("sw_data_msb", 32'(SER_DATA), 1);
    chk("sw_rs", 32'(REG_SEL), 32'(RS_CTRL));
    run_to_ready(RS_CTRL, n_lo, n_hi, n_rs, n_rl, sc);
    chk("sw_sclk_phases", 32'(sc), 32'h0C);
    chk("sw_nce_low", 32'(n_lo), 34);
    chk("sw_nce_high", 32'(n_hi), 2);
    chk("sw_ready_lat", 32'(cyc - t), 36);
    chk("sw_rises", 32'(rises - r0), 8);
    chk("sw_bits", 32'(rx[7:0]), 32'hA5);
    chk("sw_rs_stable", 32'(n_rs), 0);

    // Three-word dot frame, gapped valid, cmd toggled on words 2-3
    cw1 = '{sel: 1'b1, rsvd: 5'd0, prescale: 1'b0, serial: 1'b1};
    w = cw1;
    r0 = rises; gap_ce = 0; gap_clk = 0;
    send(w, 1'b0, 1'b0, t);
    chk("mw_rs_first", 32'(REG_SEL), 32'(RS_DOT));
    run_to_ready(RS_DOT, n_lo, n_hi, n_rs, n_rl, sc);
    chk("mw_w1_nce_high", 32'(n_hi), 0);
    for (int i = 0; i < 5; i++) begin
      if (nCE) gap_ce++;
      if (SER_CLK) gap_clk++;
      @(negedge CLK_i);
    end
    send(8'h7F, 1'b1, 1'b0, t);
    run_to_ready(RS_DOT, n_lo, n_hi, n_rs, n_rl, sc);
    chk("mw_w2_nce_high", 32'(n_hi), 0);
    chk("mw_w2_rs", 32'(n_rs), 0);
    for (int i = 0; i < 5; i++) begin
      if (nCE) gap_ce++;
      if (SER_CLK) gap_clk++;
      @(negedge CLK_i);
    end
    send(8'h00, 1'b1, 1'b1, t);
    run_to_ready(RS_DOT, n_lo, n_hi, n_rs, n_rl, sc);
    chk("mw_w3_nce_low", 32'(n_lo), 34);
    chk("mw_w3_rs", 32'(n_rs), 0);
    chk("mw_gap_nce", 32'(gap_ce), 0);
    chk("mw_gap_sclk", 32'(gap_clk), 0);
    chk("mw_rises", 32'(rises - r0), 24);
    chk("mw_bits", rx[31:0] & 32'h00FF_FFFF, 32'h0081_7F00);

    // DISP_RST together with a valid word in IDLE
    cw0 = '{sel: 1'b0, sleep_n: 1'b0, peak: 2'b11, bright: 4'hC};
    w = cw0;
    r0 = rises;
    s_if.data = w; s_if.cmd = 1'b1; s_if.last = 1'b1; s_if.valid = 1'b1;
    DISP_RST = 1'b1;
    @(negedge CLK_i);
    DISP_RST = 1'b0;
    chk("dr_nce", 32'(nCE), 1);
    pulse_len(n, n_ce_hi, n_rdy);
    chk("dr_len", 32'(n), 16);
    chk("dr_ready_low", 32'(n_rdy), 0);
    chk("dr_no_shift", 32'(rises - r0), 0);
    chk("dr_ready_after", 32'(s_if.ready), 1);
    @(negedge CLK_i);
    s_if.valid = 1'b0;
    chk("dr_accept", 32'(nCE), 0);

    // DISP_RST during SHIFT is ignored
    repeat (4) @(negedge CLK_i);
    DISP_RST = 1'b1;
    @(negedge CLK_i);
    DISP_RST = 1'b0;
    run_to_ready(RS_CTRL, n_lo, n_hi, n_rs, n_rl, sc);
    chk("ds_no_pulse", 32'(n_rl), 0);
    chk("ds_bits", 32'(rx[7:0]), 32'h3C);
    chk("ds_rises", 32'(rises - r0), 8);

    // Asynchronous reset at bit 4, then a clean word
    r0 = rises;
    send(8'hFF, 1'b0, 1'b1, t);
    for (int i = 0; i < 200 && (rises - r0) < 4; i++) @(negedge CLK_i);
    chk("ab_sclk_before", 32'(SER_CLK), 1);
    RST_ni = 1'b0;
    #1;
    chk("ab_nce", 32'(nCE), 1);
    chk("ab_sclk", 32'(SER_CLK), 0);
    chk("ab_nreset", 32'(nRESET), 0);
    @(negedge CLK_i);
    RST_ni = 1'b1;
    pulse_len(n, n_ce_hi, n_rdy);
    chk("ab_pulse_len", 32'(n), 16);
    r0 = rises;
    send(8'h5A, 1'b0, 1'b1, t);
    chk("ab_msb", 32'(SER_DATA), 0);
    run_to_ready(RS_DOT, n_lo, n_hi, n_rs, n_rl, sc);
    chk("ab_bits", 32'(rx[7:0]), 32'h5A);
    chk("ab_rises", 32'(rises - r0), 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
